// File: rtl/sap1_pkg.sv
// Shared SAP-1 encodings: opcodes, ALU operation selects and T-state codes.
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SHR = 4'b0110,
        OP_SHL = 4'b0111,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        SU_ADD = 3'b000,
        SU_SUB = 3'b001,
        SU_AND = 3'b010,
        SU_OR  = 3'b011,
        SU_NOT = 3'b100,
        SU_SHR = 3'b101,
        SU_SHL = 3'b110
    } alu_su_e;

    localparam int unsigned T1_IDX   = 0;
    localparam int unsigned T2_IDX   = 1;
    localparam int unsigned T3_IDX   = 2;
    localparam int unsigned T4_IDX   = 3;
    localparam int unsigned T5_IDX   = 4;
    localparam int unsigned T6_IDX   = 5;
    localparam int unsigned T_STATES = 6;

    typedef enum logic [T_STATES-1:0] {
        T1 = 6'b000001 << T1_IDX,
        T2 = 6'b000001 << T2_IDX,
        T3 = 6'b000001 << T3_IDX,
        T4 = 6'b000001 << T4_IDX,
        T5 = 6'b000001 << T5_IDX,
        T6 = 6'b000001 << T6_IDX
    } tstate_e;

endpackage

// File: rtl/controller_sequencer_if.sv
// Opcode input and control-word outputs of the SAP-1 controller/sequencer.
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic       pc_en;
    logic       pc_inc;
    logic       mar_ld;
    logic       ram_en;
    logic       ir_ld;
    logic       ir_en;
    logic       a_ld;
    logic       a_en;
    logic       b_ld;
    logic       out_ld;
    logic       alu_en;
    logic [2:0] alu_su;
    logic [5:0] t_state;
    logic       halted;

    modport master (
        input  opcode,
        output pc_en, pc_inc, mar_ld, ram_en, ir_ld, ir_en, a_ld, a_en,
               b_ld, out_ld, alu_en, alu_su, t_state, halted
    );

    modport slave (
        output opcode,
        input  pc_en, pc_inc, mar_ld, ram_en, ir_ld, ir_en, a_ld, a_en,
               b_ld, out_ld, alu_en, alu_su, t_state, halted
    );
endinterface

// File: rtl/ring_counter.sv
// One-hot six-state T-state generator; hold freezes it, illegal codes recover to T1.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output logic [5:0] t_state
);

    // Kept as a plain vector so a corrupted (non one-hot) value is representable and recoverable.
    logic [5:0] state_q;
    logic [5:0] state_d;

    // State register with synchronous reset to T1.
    always_ff @(posedge clk) begin
        if (rst) state_q <= T1;
        else     state_q <= state_d;
    end

    // Next state: rotate unless held; anything not one-hot returns to T1.
    always_comb begin
        state_d = T1;
        case (state_q)
            T1:      state_d = hold ? T1 : T2;
            T2:      state_d = hold ? T2 : T3;
            T3:      state_d = hold ? T3 : T4;
            T4:      state_d = hold ? T4 : T5;
            T5:      state_d = hold ? T5 : T6;
            T6:      state_d = hold ? T6 : T1;
            default: state_d = T1;
        endcase
    end

    assign t_state = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: Moore control word from T-state, opcode and halt flag.
module controller_sequencer
    import sap1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    controller_sequencer_if.master bus
);

    logic [5:0] t_state;
    logic       halted_q;
    opcode_e    op;

    assign op = opcode_e'(bus.opcode);

    ring_counter u_ring (
        .clk     (clk),
        .rst     (rst),
        .hold    (halted_q),
        .t_state (t_state)
    );

    // Halt flag: set by HLT at the end of T4, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)                                halted_q <= 1'b0;
        else if (t_state == T4 && op == OP_HLT) halted_q <= 1'b1;
    end

    // Control word decode; everything idle during reset or once halted.
    always_comb begin
        bus.pc_en  = 1'b0;
        bus.pc_inc = 1'b0;
        bus.mar_ld = 1'b0;
        bus.ram_en = 1'b0;
        bus.ir_ld  = 1'b0;
        bus.ir_en  = 1'b0;
        bus.a_ld   = 1'b0;
        bus.a_en   = 1'b0;
        bus.b_ld   = 1'b0;
        bus.out_ld = 1'b0;
        bus.alu_en = 1'b0;
        bus.alu_su = SU_ADD;
        if (!rst && !halted_q) begin
            case (t_state)
                T1: begin
                    bus.pc_en  = 1'b1;
                    bus.mar_ld = 1'b1;
                end
                T2: bus.pc_inc = 1'b1;
                T3: begin
                    bus.ram_en = 1'b1;
                    bus.ir_ld  = 1'b1;
                end
                T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            bus.ir_en  = 1'b1;
                            bus.mar_ld = 1'b1;
                        end
                        OP_NOT, OP_SHR, OP_SHL: begin
                            bus.alu_en = 1'b1;
                            bus.a_ld   = 1'b1;
                            bus.alu_su = (op == OP_NOT) ? SU_NOT :
                                         (op == OP_SHR) ? SU_SHR : SU_SHL;
                        end
                        OP_OUT: begin
                            bus.a_en   = 1'b1;
                            bus.out_ld = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (op)
                        OP_LDA: begin
                            bus.ram_en = 1'b1;
                            bus.a_ld   = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            bus.ram_en = 1'b1;
                            bus.b_ld   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (op)
                        OP_ADD: begin bus.alu_en = 1'b1; bus.a_ld = 1'b1; bus.alu_su = SU_ADD; end
                        OP_SUB: begin bus.alu_en = 1'b1; bus.a_ld = 1'b1; bus.alu_su = SU_SUB; end
                        OP_AND: begin bus.alu_en = 1'b1; bus.a_ld = 1'b1; bus.alu_su = SU_AND; end
                        OP_OR:  begin bus.alu_en = 1'b1; bus.a_ld = 1'b1; bus.alu_su = SU_OR;  end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.t_state = t_state;
    assign bus.halted  = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench: directed scenarios plus a random opcode stream against a behavioural model.
module tb_controller_sequencer;

    typedef struct packed {
        logic       pc_en;
        logic       pc_inc;
        logic       mar_ld;
        logic       ram_en;
        logic       ir_ld;
        logic       ir_en;
        logic       a_ld;
        logic       a_en;
        logic       b_ld;
        logic       out_ld;
        logic       alu_en;
        logic [2:0] alu_su;
    } ctrl_t;

    logic clk;
    logic rst;

    controller_sequencer_if sif ();

    controller_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: instruction step 0..5 (T1..T6) and halt flag.
    int unsigned m_t;
    bit          m_h;
    logic        cur_rst;
    logic [3:0]  cur_op;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word straight from the instruction timing rules.
    function automatic ctrl_t model_ctrl(input int unsigned t, input logic [3:0] op,
                                         input bit h, input logic r);
        ctrl_t c;
        bit two_operand;
        bit unary;
        c = '0;
        two_operand = (op <= 4'd4);
        unary       = (op >= 4'd5) && (op <= 4'd7);
        if (r || h) return c;
        case (t)
            0: begin c.pc_en = 1; c.mar_ld = 1; end
            1: c.pc_inc = 1;
            2: begin c.ram_en = 1; c.ir_ld = 1; end
            3: begin
                if (two_operand) begin c.ir_en = 1; c.mar_ld = 1; end
                else if (unary) begin c.alu_en = 1; c.a_ld = 1; c.alu_su = 3'(op - 4'd1); end
                else if (op == 4'd14) begin c.a_en = 1; c.out_ld = 1; end
            end
            4: begin
                if (op == 4'd0) begin c.ram_en = 1; c.a_ld = 1; end
                else if (two_operand) begin c.ram_en = 1; c.b_ld = 1; end
            end
            5: if (op >= 4'd1 && op <= 4'd4) begin c.alu_en = 1; c.a_ld = 1; c.alu_su = 3'(op - 4'd1); end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t dut_ctrl();
        return {sif.pc_en, sif.pc_inc, sif.mar_ld, sif.ram_en, sif.ir_ld, sif.ir_en,
                sif.a_ld, sif.a_en, sif.b_ld, sif.out_ld, sif.alu_en, sif.alu_su};
    endfunction

    // Drive inputs for the coming cycle, then compare outputs against the model.
    task automatic drive_check(input logic r, input logic [3:0] op);
        int drivers;
        logic [5:0] exp_t;
        rst        = r;
        sif.opcode = op;
        cur_rst    = r;
        cur_op     = op;
        #1;
        exp_t   = 6'd1 << m_t;
        drivers = int'(sif.pc_en) + int'(sif.ram_en) + int'(sif.ir_en) + int'(sif.a_en) + int'(sif.alu_en);
        check("t_state", 32'(sif.t_state), 32'(exp_t));
        check("halted", 32'(sif.halted), 32'(m_h));
        check("ctrl_word", 32'(dut_ctrl()), 32'(model_ctrl(m_t, op, m_h, r)));
        check("single_bus_driver", 32'(drivers > 1), 32'd0);
    endtask

    // Advance one clock and apply the model's update for the sampled inputs.
    task automatic advance();
        @(posedge clk);
        if (cur_rst) begin
            m_t = 0;
            m_h = 0;
        end else if (!m_h) begin
            if (m_t == 3 && cur_op == 4'hF) m_h = 1;
            m_t = (m_t + 1) % 6;
        end
        @(negedge clk);
    endtask

    // Bring the machine to the start of T1 (resetting first if halted).
    task automatic align();
        if (m_h) begin
            drive_check(1'b1, 4'h8);
            advance();
        end
        for (int i = 0; i < 6 && m_t != 0; i++) begin
            drive_check(1'b0, 4'h8);
            advance();
        end
        check("align_t1", 32'(m_t), 32'd0);
    endtask

    initial begin
        logic [5:0] exp_seq;
        logic [3:0] op;
        logic       r;

        rst        = 1'b1;
        sif.opcode = 4'h0;
        cur_rst    = 1'b1;
        cur_op     = 4'h0;
        m_t        = 0;
        m_h        = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset then run through a full ring and back to T1.
        drive_check(1'b1, 4'h0);
        check("rst_outputs_zero", 32'(dut_ctrl()), 32'd0);
        advance();
        for (int i = 0; i < 7; i++) begin
            drive_check(1'b0, 4'h8);
            exp_seq = 6'd1 << (i % 6);
            check("reset_run_seq", 32'(sif.t_state), 32'(exp_seq));
            advance();
        end

        // ADD.
        align();
        for (int k = 0; k < 6; k++) begin
            drive_check(1'b0, 4'h1);
            if (k == 3) check("add_t4_ir_en_mar_ld", {30'd0, sif.ir_en, sif.mar_ld}, 32'd3);
            if (k == 4) check("add_t5_ram_en_b_ld", {30'd0, sif.ram_en, sif.b_ld}, 32'd3);
            if (k == 5) check("add_t6_alu", {27'd0, sif.alu_en, sif.a_ld, sif.alu_su}, 32'b11000);
            advance();
        end

        // SHL.
        align();
        for (int k = 0; k < 6; k++) begin
            drive_check(1'b0, 4'h7);
            if (k == 3) check("shl_t4_alu", {27'd0, sif.alu_en, sif.a_ld, sif.alu_su}, 32'b11110);
            if (k >= 4) check("shl_t5_t6_quiet", 32'(dut_ctrl()), 32'd0);
            advance();
        end

        // HLT: freeze at T5 with outputs idle until reset.
        align();
        for (int k = 0; k < 4; k++) begin
            drive_check(1'b0, 4'hF);
            advance();
        end
        for (int k = 0; k < 21; k++) begin
            drive_check(1'b0, 4'($urandom_range(0, 15)));
            check("hlt_frozen_t5", 32'(sif.t_state), 32'b010000);
            check("hlt_flag", 32'(sif.halted), 32'd1);
            check("hlt_quiet", 32'(dut_ctrl()), 32'd0);
            advance();
        end
        drive_check(1'b1, 4'hF);
        advance();
        drive_check(1'b0, 4'h0);
        check("hlt_rst_clears", 32'(sif.halted), 32'd0);
        check("hlt_rst_t1", 32'(sif.t_state), 32'b000001);
        advance();

        // Mid-instruction reset during LDA T5.
        align();
        for (int k = 0; k < 4; k++) begin
            drive_check(1'b0, 4'h0);
            advance();
        end
        drive_check(1'b1, 4'h0);
        check("mid_rst_no_a_ld", 32'(sif.a_ld), 32'd0);
        advance();
        drive_check(1'b0, 4'h0);
        check("mid_rst_restart_t1", 32'(sif.t_state), 32'b000001);
        check("mid_rst_fetch", {30'd0, sif.pc_en, sif.mar_ld}, 32'd3);
        advance();

        // Random opcode stream with occasional resets and halts.
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 24) == 0) op = 4'hF;
            for (int k = 0; k < 6; k++) begin
                r = ($urandom_range(0, 49) == 0);
                drive_check(r, op);
                if (op >= 4'h8 && op <= 4'hD && m_t >= 3 && !m_h && !r)
                    check("nop_quiet", 32'(dut_ctrl()), 32'd0);
                advance();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), with the clock and reset listed first:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  upper nibble of the instruction register; valid from T4 onward.
- pc_en  out  1  program counter drives W bus.
- pc_inc  out  1  program counter increments.
- mar_ld  out  1  memory address register loads from W bus.
- ram_en  out  1  RAM drives W bus.
- ir_ld  out  1  instruction register loads from W bus.
- ir_en  out  1  instruction register drives its operand nibble onto W bus.
- a_ld  out  1  accumulator loads from W bus.
- a_en  out  1  accumulator drives W bus.
- b_ld  out  1  B register loads from W bus.
- out_ld  out  1  output register loads from W bus.
- alu_en  out  1  ALU drives W bus.
- alu_su  out  3  ALU operation select.
- t_state  out  6  one-hot T-state, bit0 = T1.
- halted  out  1  HLT has executed.

Function
REQ-002 Opcode map SHALL be: LDA 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, NOT 0101, SHR 0110, SHL 0111, OUT 1110, HLT 1111; opcodes 1000-1101 SHALL execute as NOP.
REQ-003 Every instruction SHALL take exactly six cycles, T1 through T6, and then return to T1; no early exit.
REQ-004 Outputs SHALL be Moore outputs, decoded combinationally from the registered T-state, the opcode and halted; the control word is valid for the whole cycle of its T-state.
REQ-005 In T1, pc_en and mar_ld SHALL be asserted.
REQ-006 In T2, pc_inc SHALL be asserted.
REQ-007 In T3, ram_en and ir_ld SHALL be asserted.
REQ-008 In T4 for LDA/ADD/SUB/AND/OR, ir_en and mar_ld SHALL be asserted.
REQ-009 In T4 for NOT/SHR/SHL, alu_en and a_ld SHALL be asserted with alu_su 100/101/110 respectively.
REQ-010 In T4 for OUT, a_en and out_ld SHALL be asserted.
REQ-011 In T5, LDA SHALL assert ram_en and a_ld; ADD/SUB/AND/OR SHALL assert ram_en and b_ld.
REQ-012 In T6, ADD/SUB/AND/OR SHALL assert alu_en and a_ld with alu_su 000/001/010/011 respectively.
REQ-013 All control outputs not listed for a T-state/opcode pair SHALL be 0.
REQ-014 alu_su SHALL be 000 whenever alu_en is 0.
REQ-015 At most one of pc_en, ram_en, ir_en, a_en, alu_en SHALL be 1 in any cycle (single W-bus driver).
REQ-016 On HLT in T4, halted SHALL be set at the next rising edge and remain set until rst.
REQ-017 While halted is 1, the T-state SHALL freeze and all control outputs SHALL be 0.
REQ-018 t_state SHALL always be exactly one-hot; an illegal encoding SHALL recover to T1 on the next edge.

Reset
REQ-019 rst sampled high SHALL set t_state to 000001 and clear halted at that edge; rst SHALL take priority over all other activity.
REQ-020 While rst is high, all control outputs SHALL be forced to 0 and alu_su to 000.
REQ-021 rst asserted mid-instruction SHALL abandon the instruction; fetch SHALL restart at T1 on the first cycle after rst deasserts.

Structure
REQ-022 Package sap1_pkg SHALL hold the opcode constants, the ALU su codes (000-110) and the T-state index constants, shared with the ALU and the bench.
REQ-023 The T-state generator SHALL be a separate sub-module, ring_counter (clk, rst, hold, t_state[5:0]); hold is driven by halted.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset then run: rst high 2 cycles, then low -> t_state sequence 000001, 000010, 000100, 001000, 010000, 100000, then 000001.
- ADD (opcode 0001): T4 ir_en=1, mar_ld=1; T5 ram_en=1, b_ld=1; T6 alu_en=1, a_ld=1, alu_su=000.
- SHL (opcode 0111): T4 alu_en=1, a_ld=1, alu_su=110; T5 and T6 all control outputs 0.
- HLT (opcode 1111): halted=1 from T5 onward; t_state frozen at 010000; all control outputs 0 for 20 cycles; rst -> halted=0, t_state=000001.
- Mid-instruction reset: rst in T5 of LDA -> no a_ld pulse; next cycle after rst drops is T1 with pc_en=1, mar_ld=1.
- Bus-exclusivity assertion across a random opcode stream, including 1000-1101 -> never more than one bus driver high; NOP T4-T6 all control outputs 0.
